mult_nm_2_nm_seq: RTL and testbench

- Sequential signed multiplier, the inverse operation of the team's N-by-M signed divider.
- Computes o = g_input * e_input (both signed two's complement) as an exact signed N+M-bit product, one multiplier bit per clock (shift-add).
- Used wherever a divider quotient is re-scaled, and as the multiply stage in sequential garbled-circuit benchmarks, where low gate count outweighs latency.

---
 rtl/mult_nm_2_nm_seq.sv | 128 ++++++++++++
 tb/tb_mult_nm_2_nm_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_nm_2_nm_seq.sv
// rtl/mult_nm_2_nm_seq.sv - sequential signed N x M shift-add multiplier, one multiplier bit per clock
module mult_nm_2_nm_seq #(
  parameter int N = 32,
  parameter int M = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     g_input,
  input  logic [M-1:0]     e_input,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   o
);

  localparam int W  = N + M;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(M - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_mcand;
  logic [M-1:0]    r_mplier;
  logic [W-1:0]    r_o;
  logic            r_done;
  logic            r_busy;

  logic [CW-1:0]   w_cnt_nxt;
  logic [W-1:0]    w_acc_nxt;
  logic [W-1:0]    w_mcand_nxt;
  logic [M-1:0]    w_mplier_nxt;
  logic [W-1:0]    w_o_nxt;
  logic            w_done_nxt;
  logic            w_busy_nxt;

  // The multiplier register shifts right each step, so its bit 0 is always
  // the bit of weight 2^cnt; the multiplicand shifts left to match that weight.
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_sum;
  logic [W-1:0]    w_diff;
  logic            w_last;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;
  // The top multiplier bit carries weight -2^(M-1), so it is subtracted.
  assign w_diff   = r_acc - w_addend;
  assign w_last   = (r_cnt == LAST_BIT);

  // Next-state and datapath update: idle loads operands, run does one shift-add step
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_o_nxt      = r_o;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_nxt  = {{M{g_input[N-1]}}, g_input};
          w_mplier_nxt = e_input;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        w_acc_nxt    = w_last ? w_diff : w_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        if (w_last) begin
          // Counter parks at zero so it never wraps past M-1 for power-of-two M.
          w_cnt_nxt   = '0;
          w_o_nxt     = w_diff;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and discards any partial product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_o      <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_o      <= w_o_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign o    = r_o;

endmodule

// File: tb/tb_mult_nm_2_nm_seq.sv
// tb/tb_mult_nm_2_nm_seq.sv - scoreboard bench for the sequential signed multiplier
`timescale 1ns/1ps
module tb_mult_nm_2_nm_seq;

  localparam int N = 32;
  localparam int M = 28;
  localparam int W = N + M;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   g_input;
  logic [M-1:0]   e_input;
  logic           busy;
  logic           done;
  logic [W-1:0]   o;

  int             n_checks;
  int             n_errors;
  int             n_done;
  int             n_push;
  logic [W-1:0]   exp_q[$];

  mult_nm_2_nm_seq #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g_input (g_input),
    .e_input (e_input),
    .busy    (busy),
    .done    (done),
    .o       (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] ex);
    exp_q.push_back(ex);
    n_push++;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'd0);
      else check("product", 64'(o), 64'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input logic [N-1:0] g, input logic [M-1:0] e, input logic [W-1:0] ex);
    int waitc;
    int lat;
    waitc = 0;
    while (busy && waitc < 200) begin
      step();
      waitc++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
    g_input = g;
    e_input = e;
    start   = 1'b1;
    push_exp(ex);
    step();
    start   = 1'b0;
    g_input = N'($urandom);
    e_input = M'($urandom);
    check("busy_on_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < M + 10) begin
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(M));
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] g, input logic [M-1:0] e);
    longint p;
    p = longint'($signed(g)) * longint'($signed(e));
    return p[W-1:0];
  endfunction

  initial begin
    int doneat;
    int last_acc;
    int n_acc;
    logic prev_busy;
    logic [N-1:0] rg;
    logic [M-1:0] re;

    n_checks = 0;
    n_errors = 0;
    n_done   = 0;
    n_push   = 0;
    rst      = 1'b1;
    start    = 1'b1;
    g_input  = '0;
    e_input  = '0;
    step();
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_o", 64'(o), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    step();

    // Directed products, issued back to back (next start lands in the done cycle)
    run_op(32'hFFFFFFFF, 28'hFFFFFFF, 60'd1);
    run_op(32'hFFFFFFFF, 28'h0000047, 60'hFFFFFFFFFFFFFB9);
    run_op(32'h7FFFFFFF, -28'sd71, -60'sd152471338937);
    run_op(-32'sd66, 28'd71, -60'sd4686);
    run_op(32'h80000000, 28'h8000000, 60'h400000000000000);
    run_op(32'd0, 28'hFFFFFFF, 60'd0);
    run_op(32'd12345, 28'd0, 60'd0);

    // Random operands against a native 64-bit signed product
    for (int i = 0; i < 4; i++) begin
      rg = N'($urandom);
      re = M'($urandom);
      run_op(rg, re, model(rg, re));
    end

    // Starts with other operands while busy are ignored
    g_input = 32'd71;
    e_input = 28'd71;
    start   = 1'b1;
    push_exp(60'd5041);
    step();
    start  = 1'b0;
    doneat = -1;
    for (int c = 1; c <= M + 4; c++) begin
      start = (c == 5 || c == 20);
      if (start) begin
        g_input = 32'd3;
        e_input = 28'd5;
      end
      step();
      if (done) doneat = c;
    end
    start = 1'b0;
    check("ignored_start_done_at", 64'(doneat), 64'(M));
    check("ignored_start_idle", 64'(busy), 64'd0);
    check("o_held", 64'(o), 64'd5041);

    // Start held high: one accepted operation every M+1 cycles
    g_input   = -32'sd9;
    e_input   = 28'd1000;
    start     = 1'b1;
    prev_busy = busy;
    last_acc  = -1;
    n_acc     = 0;
    for (int c = 0; c < 3 * (M + 1); c++) begin
      step();
      if (busy && !prev_busy) begin
        if (n_acc > 0) check("held_interval", 64'(c - last_acc), 64'(M + 1));
        last_acc = c;
        n_acc++;
        push_exp(-60'sd9000);
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("held_accepts", 64'(n_acc), 64'd3);
    step();
    step();

    // Reset in the middle of a run discards the partial product
    g_input = 32'd5;
    e_input = 28'd7;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_o", 64'(o), 64'd0);
    repeat (M + 3) step();
    run_op(32'd100, 28'd19, 60'd1900);
    step();

    check("done_count", 64'(n_done), 64'(n_push));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
